// File: rtl/mem_dp_pkg.sv
// Shared types for the dual-port memory: FSM states and error cause codes.
// No logic here; the merge helper just packs the two error cause bits.
// Imported by the top; the read pipe needs nothing from it.
package mem_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_RANGE = 2'b01;
  localparam logic [1:0] ERR_BUSY  = 2'b10;
  localparam logic [1:0] ERR_BOTH  = 2'b11;

  // Busy cause is the upper bit and range cause the lower bit, so both
  // together naturally give ERR_BOTH.
  function automatic logic [1:0] err_merge(input logic range_hit, input logic busy_hit);
    return {busy_hit, range_hit};
  endfunction

endpackage

// File: rtl/mem_dp_if.sv
// Request/response bundle of the dual-port memory (write port, read port, status).
// Purely wiring: no latency of its own.
// No backpressure: requests are fire-and-forget, refused ones show up on err.
interface mem_dp_if #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 3
);

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  err_clr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  busy;
  logic                  err;
  logic [1:0]            err_code;

  // Requester side
  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr, err_clr,
    input  rd_data, rd_valid, busy, err, err_code
  );

  // Memory side
  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr, err_clr,
    output rd_data, rd_valid, busy, err, err_code
  );

endinterface

// File: rtl/mem_dp_rd_pipe.sv
// Read output register chain carrying valid and data.
// Latency: LATENCY clocks from vld_i to vld_o.
// No backpressure; each stage only reloads data when its input is valid, so dat_o holds.
module mem_rd_pipe #(
  parameter int DATA_WIDTH = 6,
  parameter int LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vld_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic                  vld_o,
  output logic [DATA_WIDTH-1:0] dat_o
);

  logic [LATENCY-1:0]    vld_q;
  logic [DATA_WIDTH-1:0] dat_q [LATENCY];

  // Shift valid every clock; data only advances alongside a valid beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= vld_i;
      if (vld_i) dat_q[0] <= dat_i;
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign vld_o = vld_q[LATENCY-1];
  assign dat_o = dat_q[LATENCY-1];

endmodule

// File: rtl/mem_dp.sv
// Simple dual-port memory with post-reset init sweep, write-first bypass and sticky error.
// Latency: read data valid READ_LATENCY clocks after the edge sampling rd_en.
// No backpressure: requests during the sweep or out of range are dropped and flagged.
module mem_dp
  import mem_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 6,
  parameter int                    ADDR_WIDTH   = 3,
  parameter int                    RAM_DEPTH    = 8,
  parameter int                    READ_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
  input  logic     clk,
  input  logic     RESET,
  mem_dp_if.slave  bus
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH+1)'(RAM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

  // Storage has no reset: the sweep is what initialises it.
  logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] sweep_q;
  logic                  busy_q;

  logic                  err_q, err_d;
  logic [1:0]            err_code_q, err_code_d;

  logic                  rd_req_q;
  logic                  rd_zero_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [DATA_WIDTH-1:0] rd_word;

  logic                  wr_in_rng, rd_in_rng;
  logic                  run, wr_ok, rd_go;
  logic                  range_hit, busy_hit;
  logic [1:0]            new_code;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_wa;
  logic [DATA_WIDTH-1:0] mem_wd;

  assign wr_in_rng = {1'b0, bus.wr_addr} < DEPTH_W;
  assign rd_in_rng = {1'b0, bus.rd_addr} < DEPTH_W;
  assign run       = (state_q == ST_RUN);
  assign wr_ok     = run & bus.wr_en & wr_in_rng;
  // Out-of-range reads still produce a (zero) response; only the sweep blocks reads.
  assign rd_go     = run & bus.rd_en;

  // An out-of-range address is an error whether or not the sweep is running;
  // any request at all during the sweep is a busy error.
  assign range_hit = (bus.wr_en & ~wr_in_rng) | (bus.rd_en & ~rd_in_rng);
  assign busy_hit  = ~run & (bus.wr_en | bus.rd_en);
  assign new_code  = err_merge(range_hit, busy_hit);

  // Single write port shared between the sweep and the user write path
  always_comb begin
    mem_we = 1'b0;
    mem_wa = bus.wr_addr;
    mem_wd = bus.wr_data;
    if (!RESET) begin
      if (!run) begin
        mem_we = 1'b1;
        mem_wa = sweep_q;
        mem_wd = INIT_VALUE;
      end else begin
        mem_we = wr_ok;
      end
    end
  end

  // Storage write; reads happen one edge later so a same-edge write is seen (write-first)
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_wa] <= mem_wd;
  end

  // Init sweep / run FSM with registered busy
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_INIT;
      sweep_q <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (sweep_q == LAST_ADDR) begin
            state_q <= ST_RUN;
            sweep_q <= '0;
            busy_q  <= 1'b0;
          end else begin
            sweep_q <= sweep_q + 1'b1;
          end
        end
        ST_RUN: begin
          busy_q <= 1'b0;
        end
        default: begin
          state_q <= ST_INIT;
          sweep_q <= '0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  // Sticky error: first cause latched, a new error beats a same-cycle clear
  always_comb begin
    err_d      = err_q;
    err_code_d = err_code_q;
    if (new_code != ERR_NONE) begin
      err_d = 1'b1;
      if (!err_q || bus.err_clr) err_code_d = new_code;
    end else if (bus.err_clr) begin
      err_d      = 1'b0;
      err_code_d = ERR_NONE;
    end
  end

  // Error state registers
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  // Capture the accepted read request; the array is looked up after the write lands
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      rd_req_q  <= 1'b0;
      rd_zero_q <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      rd_req_q <= rd_go;
      if (rd_go) begin
        rd_zero_q <= ~rd_in_rng;
        rd_addr_q <= bus.rd_addr;
      end
    end
  end

  assign rd_word = rd_zero_q ? '0 : mem_q[rd_addr_q];

  mem_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .LATENCY    (READ_LATENCY)
  ) u_rd_pipe (
    .clk   (clk),
    .rst   (RESET),
    .vld_i (rd_req_q),
    .dat_i (rd_word),
    .vld_o (bus.rd_valid),
    .dat_o (bus.rd_data)
  );

  assign bus.busy     = busy_q;
  assign bus.err      = err_q;
  assign bus.err_code = err_code_q;

endmodule

// File: tb/tb_mem_dp.sv
// Bench for mem_dp: three instances (depth 8/lat 1, depth 8/lat 2, depth 6/lat 1)
// driven with identical stimulus; a per-instance model predicts flags and
// read responses, which are queued and matched against rd_valid beats.
module tb_mem_dp;

  typedef struct {
    int         due;
    logic [5:0] dat;
  } exp_t;

  localparam int         DEP [3] = '{8, 8, 6};
  localparam int         LAT [3] = '{1, 2, 1};
  localparam logic [5:0] INIT    = 6'h15;

  logic clk   = 1'b0;
  logic RESET = 1'b1;
  int   cyc   = 0;
  int   n_chk = 0;
  int   n_bad = 0;

  exp_t       sb        [3][$];
  logic [5:0] mdl_mem   [3][8];
  int         init_left [3];
  logic       m_err     [3];
  logic [1:0] m_code    [3];

  mem_dp_if #(.DATA_WIDTH(6), .ADDR_WIDTH(3)) if0 ();
  mem_dp_if #(.DATA_WIDTH(6), .ADDR_WIDTH(3)) if1 ();
  mem_dp_if #(.DATA_WIDTH(6), .ADDR_WIDTH(3)) if2 ();

  mem_dp #(.DATA_WIDTH(6), .ADDR_WIDTH(3), .RAM_DEPTH(8), .READ_LATENCY(1), .INIT_VALUE(INIT))
    u_dut0 (.clk(clk), .RESET(RESET), .bus(if0));
  mem_dp #(.DATA_WIDTH(6), .ADDR_WIDTH(3), .RAM_DEPTH(8), .READ_LATENCY(2), .INIT_VALUE(INIT))
    u_dut1 (.clk(clk), .RESET(RESET), .bus(if1));
  mem_dp #(.DATA_WIDTH(6), .ADDR_WIDTH(3), .RAM_DEPTH(6), .READ_LATENCY(1), .INIT_VALUE(INIT))
    u_dut2 (.clk(clk), .RESET(RESET), .bus(if2));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s obs=%0h exp=%0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic drive(input logic we, input logic [2:0] wa, input logic [5:0] wd,
                       input logic re, input logic [2:0] ra, input logic clr);
    if0.wr_en = we; if0.wr_addr = wa; if0.wr_data = wd;
    if0.rd_en = re; if0.rd_addr = ra; if0.err_clr = clr;
    if1.wr_en = we; if1.wr_addr = wa; if1.wr_data = wd;
    if1.rd_en = re; if1.rd_addr = ra; if1.err_clr = clr;
    if2.wr_en = we; if2.wr_addr = wa; if2.wr_data = wd;
    if2.rd_en = re; if2.rd_addr = ra; if2.err_clr = clr;
  endtask

  // Predict what the coming edge does to instance id
  task automatic model(input int id, input logic we, input logic [2:0] wa, input logic [5:0] wd,
                       input logic re, input logic [2:0] ra, input logic clr);
    int         e_n;
    logic       busy_now, rng, bsy;
    logic [1:0] code;
    logic [5:0] d;
    exp_t       e;
    e_n      = cyc + 1;
    busy_now = init_left[id] > 0;
    rng      = (we && int'(wa) >= DEP[id]) || (re && int'(ra) >= DEP[id]);
    bsy      = busy_now && (we || re);
    code     = {bsy, rng};
    if (!busy_now && re) begin
      if (int'(ra) >= DEP[id]) d = 6'h00;
      else if (we && wa == ra) d = wd;
      else d = mdl_mem[id][ra];
      e.due = e_n + LAT[id];
      e.dat = d;
      sb[id].push_back(e);
    end
    if (busy_now) begin
      mdl_mem[id][DEP[id] - init_left[id]] = INIT;
      init_left[id]--;
    end else if (we && int'(wa) < DEP[id]) begin
      mdl_mem[id][wa] = wd;
    end
    if (code != 2'b00) begin
      if (!m_err[id] || clr) m_code[id] = code;
      m_err[id] = 1'b1;
    end else if (clr) begin
      m_err[id]  = 1'b0;
      m_code[id] = 2'b00;
    end
  endtask

  task automatic check_flags(input int id, input logic busy, input logic err, input logic [1:0] code);
    chk($sformatf("busy%0d", id), 32'(busy), 32'(init_left[id] > 0));
    chk($sformatf("err%0d", id), 32'(err), 32'(m_err[id]));
    chk($sformatf("err_code%0d", id), 32'(code), 32'(m_code[id]));
  endtask

  task automatic step(input logic we, input logic [2:0] wa, input logic [5:0] wd,
                      input logic re, input logic [2:0] ra, input logic clr);
    drive(we, wa, wd, re, ra, clr);
    for (int id = 0; id < 3; id++) model(id, we, wa, wd, re, ra, clr);
    @(posedge clk);
    #1;
    check_flags(0, if0.busy, if0.err, if0.err_code);
    check_flags(1, if1.busy, if1.err, if1.err_code);
    check_flags(2, if2.busy, if2.err, if2.err_code);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 6'h00, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic rd(input logic [2:0] a);
    step(1'b0, 3'd0, 6'h00, 1'b1, a, 1'b0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [5:0] d);
    step(1'b1, a, d, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic clr_err();
    step(1'b0, 3'd0, 6'h00, 1'b0, 3'd0, 1'b1);
  endtask

  task automatic reset_chk(input int id, input logic busy, input logic vld, input logic [5:0] dat,
                           input logic err, input logic [1:0] code);
    chk($sformatf("rst_busy%0d", id), 32'(busy), 32'(1));
    chk($sformatf("rst_rd_valid%0d", id), 32'(vld), 32'(0));
    chk($sformatf("rst_rd_data%0d", id), 32'(dat), 32'(0));
    chk($sformatf("rst_err%0d", id), 32'(err), 32'(0));
    chk($sformatf("rst_err_code%0d", id), 32'(code), 32'(0));
  endtask

  // One-cycle reset pulse; in-flight reads are forgotten
  task automatic do_reset();
    drive(1'b0, 3'd0, 6'h00, 1'b0, 3'd0, 1'b0);
    RESET = 1'b1;
    for (int id = 0; id < 3; id++) begin
      sb[id].delete();
      init_left[id] = DEP[id];
      m_err[id]     = 1'b0;
      m_code[id]    = 2'b00;
    end
    @(posedge clk);
    #1;
    reset_chk(0, if0.busy, if0.rd_valid, if0.rd_data, if0.err, if0.err_code);
    reset_chk(1, if1.busy, if1.rd_valid, if1.rd_data, if1.err, if1.err_code);
    reset_chk(2, if2.busy, if2.rd_valid, if2.rd_data, if2.err, if2.err_code);
    RESET = 1'b0;
  endtask

  // Match each rd_valid beat against the oldest expected read response
  task automatic mon(input int id, input logic vld, input logic [5:0] dat);
    exp_t e;
    if (vld) begin
      if (sb[id].size() == 0) begin
        chk($sformatf("rd_valid_extra%0d", id), 32'(vld), 32'(0));
      end else begin
        e = sb[id].pop_front();
        chk($sformatf("rd_cycle%0d", id), 32'(cyc), 32'(e.due));
        chk($sformatf("rd_data%0d", id), 32'(dat), 32'(e.dat));
      end
    end else if (sb[id].size() > 0 && sb[id][0].due <= cyc) begin
      chk($sformatf("rd_valid_miss%0d", id), 32'(vld), 32'(1));
      void'(sb[id].pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (!RESET) begin
      mon(0, if0.rd_valid, if0.rd_data);
      mon(1, if1.rd_valid, if1.rd_data);
      mon(2, if2.rd_valid, if2.rd_data);
    end
  end

  initial begin
    drive(1'b0, 3'd0, 6'h00, 1'b0, 3'd0, 1'b0);
    #2;
    do_reset();

    // Sweep, then read back every address
    idle(9);
    for (int a = 0; a < 8; a++) rd(3'(a));
    idle(3);
    clr_err();

    // Plain write then read
    wr(3'd3, 6'h2A);
    rd(3'd3);
    idle(3);

    // Write-first collision, then different-address read sees old data
    step(1'b1, 3'd5, 6'h11, 1'b1, 3'd5, 1'b0);
    step(1'b1, 3'd5, 6'h22, 1'b1, 3'd6, 1'b0);
    rd(3'd5);
    idle(3);

    // Address 7 is past the end of the depth-6 instance
    wr(3'd7, 6'h3F);
    rd(3'd6);
    rd(3'd7);
    idle(2);
    clr_err();
    idle(1);

    // Back-to-back mixed traffic
    for (int i = 0; i < 40; i++) begin
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 6'($urandom),
           1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 7) == 0));
    end
    idle(3);
    clr_err();

    // Reset with a read in flight, then requests during the sweep
    rd(3'd2);
    do_reset();
    rd(3'd1);
    step(1'b0, 3'd0, 6'h00, 1'b1, 3'd7, 1'b1);
    idle(2);
    do_reset();
    idle(9);
    for (int a = 0; a < 8; a++) rd(3'(a));
    idle(3);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_dp.md
# mem_dp

Parametrised simple-dual-port memory: the next generation of the team's single-port `mem`, with independent read and write ports usable in the same cycle. Post-reset contents are initialised by a sweep state machine rather than a parallel clear. The block has a configurable read pipeline depth and write-first collision bypass. A sticky error flag flags out-of-range or illegal accesses and is cleared explicitly. It sits between the packet datapath and the FIFO/arbiter blocks as their generic storage element.

## Interface
- `DATA_WIDTH`, 6: word width in bits.
- `ADDR_WIDTH`, 3: address width in bits.
- `RAM_DEPTH`, 8: number of words; legal range 2..2**ADDR_WIDTH.
- `READ_LATENCY`, 1: clocks from `rd_en` sample to `rd_valid`; legal values 1 or 2.
- `INIT_VALUE`, 0: value written to every word by the init sweep.
- `clk` in 1: single clock; all logic on the rising edge.
- `RESET` in 1: reset is asynchronous and active-high.
- `wr_en` in 1: write request, sampled each rising edge.
- `wr_addr` in ADDR_WIDTH: write address.
- `wr_data` in DATA_WIDTH: write data.
- `rd_en` in 1: read request, sampled each rising edge.
- `rd_addr` in ADDR_WIDTH: read address.
- `err_clr` in 1: clears `err` and `err_code`.
- `rd_data` out DATA_WIDTH: read data; valid only while `rd_valid`=1.
- `rd_valid` out 1: one-cycle pulse per accepted read.
- `busy` out 1: high while the init sweep runs; all requests are refused.
- `err` out 1: sticky error flag.
- `err_code` out 2: cause of the first error since the last clear. 01 = out-of-range address, 10 = request while busy, 11 = both in the same cycle.

## Operation
- FSM states are INIT and RUN. `RESET` forces INIT, zeroes the sweep counter, and clears every pipeline register; contents are not cleared in parallel.
- INIT: one word per clock, addresses 0..RAM_DEPTH-1 ascending, writing `INIT_VALUE`. After the write to RAM_DEPTH-1, the FSM moves to RUN. No other exit.
- RUN, write: `wr_en`=1 with `wr_addr`<RAM_DEPTH writes `wr_data`. If `wr_addr`>=RAM_DEPTH, the write is dropped and an error is raised.
- RUN, read: `rd_en`=1 returns `mem[rd_addr]` with `rd_valid`. If `rd_addr`>=RAM_DEPTH, `rd_data`=0 with `rd_valid`=1 and an error is raised.
- Collision: `wr_en` and `rd_en` at the same legal address in the same cycle give write-first behaviour. The read returns the new `wr_data`. Different addresses proceed independently. This replaces the old read+write = error rule.
- Requests while `busy`=1 are dropped, raise error code 10, and produce no `rd_valid`.
- Error flag: `err` is set on any error and holds until `err_clr`. `err_code` latches the first cause only. If `err_clr` and a new error occur in the same cycle, the set wins and `err_code` takes the new cause.
- Reset mid-sweep or mid-read: the in-flight read is discarded (no `rd_valid`) and the sweep restarts at address 0.

## Timing
- Reset values: `busy`=1, `rd_valid`=0, `rd_data`=0, `err`=0, `err_code`=00.
- Init sweep: the first rising edge after `RESET` falls writes address 0. Edge k writes address k-1. `busy` falls on edge RAM_DEPTH. The first request is accepted at edge RAM_DEPTH+1.
- Read latency: with `rd_en` sampled at edge N, `rd_valid` and `rd_data` are registered at edge N+READ_LATENCY.
- Throughput: one read and one write per clock; back-to-back reads give consecutive `rd_valid` pulses.
- `rd_data` holds its last value when `rd_valid`=0.
- Error timing: `err` and `err_code` are registered on the edge that samples the offending request.

## Structure
- Package `mem_pkg`: FSM state enum (`ST_INIT`, `ST_RUN`) and `err_code` localparams (`ERR_NONE`, `ERR_RANGE`, `ERR_BUSY`, `ERR_BOTH`).
- Sub-module `mem_rd_pipe`: parametrised output register chain of READ_LATENCY stages carrying valid and data, with async reset. Instantiated once.
- The storage array, sweep counter, FSM and error logic live in `mem_dp`.

## Test plan
- Reset, then idle with RAM_DEPTH=8 and INIT_VALUE=6'h15 → `busy`=1 for exactly 8 edges. Reading every address then returns 6'h15.
- Write 6'h2A at address 3, then read address 3 at READ_LATENCY=1 and again at READ_LATENCY=2 → `rd_data`=6'h2A one or two edges later, respectively, with one `rd_valid` pulse each.
- Same-cycle write 6'h11 and read both at address 5 → `rd_data`=6'h11. Same-cycle write at address 5 with read at address 6 → old address-6 contents.
- With RAM_DEPTH=6, write address 7, then read address 6 → address 7 is unchanged, `rd_data`=0 with `rd_valid`=1, and `err`=1 with `err_code`=01. `err_clr` alone then gives `err`=0. `err_clr` together with a new busy error gives `err_code`=10.
- `rd_en` during INIT → no `rd_valid`, `err_code`=10. Assert `RESET` for one cycle at sweep address 4 → sweep restarts at 0 and `busy` lasts a full RAM_DEPTH edges again.
